clock_mmss_counter: RTL and testbench
=====================================

Name: clock_mmss_counter

Overview:
Time base and minutes/seconds stage of the digital clock. It divides the system clock to a 1 s tick and keeps BCD seconds (00-59) and minutes (00-59). It issues a one-cycle hour_add pulse on the 59:59 -> 00:00 rollover. That pulse drives the add input of the downstream 24-hour BCD hour counter.
Also handles user adjustment of the seconds and minutes fields via debounced-level add/sub buttons, with edge detection.

Parameters:
DIV, 50000000, clk cycles per second; must be >= 2
CNT_W, $clog2(DIV), prescaler counter width (derived)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  1 = timekeeping enabled; 0 = prescaler frozen
hold  input  1  freeze everything (counters, prescaler, pulses forced 0)
sel  input  1  adjust target: 0 = seconds, 1 = minutes
add  input  1  level button; rising edge = +1 on selected field
sub  input  1  level button; rising edge = -1 on selected field
sec_low  output  4  seconds units BCD (0-9)
sec_high  output  4  seconds tens BCD (0-5)
min_low  output  4  minutes units BCD (0-9)
min_high  output  4  minutes tens BCD (0-5)
tick  output  1  one-cycle pulse, registered with each 1 s advance
hour_add  output  1  one-cycle pulse on the 59:59 -> 00:00 timekeeping rollover

Behaviour:
- Reset (rst_n=0 at an edge): all digits 0, prescaler 0, tick=0, hour_add=0, add/sub edge registers cleared to 0. Reset overrides everything. A mid-operation reset discards any pending tick.
- Edge detect: add_rise = add & ~add_q and sub_rise = sub & ~sub_q. add_q and sub_q update every non-reset cycle, including during hold.
- Priority each cycle: reset > hold > adjust > timekeeping.
- Hold=1: all digits and the prescaler keep their values; tick=0, hour_add=0. Edges that occur during hold are consumed and not replayed afterwards.
- Adjust (hold=0, exactly one of add_rise/sub_rise):
  - Selected field steps ±1 mod 60 in BCD: 59+1 -> 00, 00-1 -> 59, x9+1 -> (x+1)0, x0-1 -> (x-1)9.
  - There is no carry or borrow into the other field, and hour_add stays 0.
  - The prescaler is cleared to 0, any tick due that cycle is dropped, and tick=0.
- add_rise and sub_rise in the same cycle: no change, prescaler unaffected (timekeeping proceeds normally).
- Timekeeping (hold=0, no adjust, run=1):
  - The prescaler increments each cycle. When it equals DIV-1 it wraps to 0 and the time advances at that same edge.
  - tick=1 for the cycle after that edge, i.e. registered with the new digit values.
  - Seconds advance in BCD. Seconds 59 -> 00 increments minutes. Minutes 59 -> 00 together with seconds 59 -> 00 sets hour_add=1 for exactly that one cycle.
- run=0: prescaler frozen (not cleared); tick=0, hour_add=0; adjust still works.
- tick and hour_add are 0 in every cycle where they are not explicitly asserted.
- Digits never leave their legal BCD range. First tick after reset occurs DIV cycles after rst_n rises with run=1.

Decomposition:
- Package clock_pkg: BCD constants (DIGIT_MAX=9, TENS_MAX=5) and a typedef for a 4-bit BCD digit. The downstream hour counter reuses this package.
- Sub-module bcd60_counter (instantiated twice, for seconds and minutes):
  - Inputs: clk, rst_n, inc, dec, en.
  - Outputs: low, high, and a combinational wrap flag (true when the value is 59 and inc is asserted).
- Prescaler and edge detectors live in the top level.

Test Plan (DIV=4):
- Reset: hold rst_n=0 for 2 cycles with run=1 -> all digits 0, tick=0, hour_add=0. After release, first tick occurs 4 cycles later with seconds=01, then every 4 cycles.
- Preset by borrow: sel=0 sub pulse -> sec 59; sel=1 sub pulse -> min 59, hour_add stays 0. Run 4 cycles -> 00:00, hour_add=1 for exactly one cycle, tick=1 same cycle.
- Carries: seconds 09 -> 10 on tick; at 00:59 next tick -> 01:00 with hour_add=0.
- Hold: hold=1 for 10 cycles mid-prescaler (count 2) -> digits unchanged, no tick. Release -> tick after exactly 2 more cycles. An add edge inside hold is ignored.
- Buttons: add held high for 20 cycles with sel=1 -> minutes +1 only. add and sub rising the same cycle -> no change. An adjust on a tick cycle -> tick suppressed, prescaler restarts, next tick 4 cycles later.
- Reset mid-run at 12:34 with prescaler=3 -> 00:00, tick=0, hour_add=0 the next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared BCD definitions for the clock stages (mm:ss here, hours downstream).
package clock_pkg;
  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t TENS_MAX  = 4'd5;
endpackage

// File: rtl/clock_mmss_counter_if.sv
// Control inputs and BCD display outputs of the mm:ss stage.
interface clock_mmss_counter_if;
  import clock_pkg::*;

  logic run;
  logic hold;
  logic sel;
  logic add;
  logic sub;
  bcd_t sec_low;
  bcd_t sec_high;
  bcd_t min_low;
  bcd_t min_high;
  logic tick;
  logic hour_add;

  modport master (
    output run, hold, sel, add, sub,
    input  sec_low, sec_high, min_low, min_high, tick, hour_add
  );

  modport slave (
    input  run, hold, sel, add, sub,
    output sec_low, sec_high, min_low, min_high, tick, hour_add
  );
endinterface

// File: rtl/bcd60_counter.sv
// Two-digit BCD modulo-60 up/down counter; wrap flags the 59 -> 00 increment.
module bcd60_counter
  import clock_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic en,
  output bcd_t low,
  output bcd_t high,
  output logic wrap
);

  assign wrap = inc && (low == DIGIT_MAX) && (high == TENS_MAX);

  // inc and dec together cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      low  <= '0;
      high <= '0;
    end else if (en && (inc ^ dec)) begin
      if (inc) begin
        if (low == DIGIT_MAX) begin
          low  <= '0;
          high <= (high == TENS_MAX) ? 4'd0 : high + 4'd1;
        end else begin
          low  <= low + 4'd1;
        end
      end else begin
        if (low == 4'd0) begin
          low  <= DIGIT_MAX;
          high <= (high == 4'd0) ? TENS_MAX : high - 4'd1;
        end else begin
          low  <= low - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_mmss_counter.sv
// 1 s time base plus BCD seconds/minutes with button adjust and hour carry pulse.
module clock_mmss_counter
  import clock_pkg::*;
#(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  clock_mmss_counter_if.slave io
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] pre;
  logic             add_q, sub_q;
  logic             add_rise, sub_rise;
  logic             adj, adv;
  logic             sec_inc, sec_dec, min_inc, min_dec;
  logic             sec_wrap, min_wrap;

  assign add_rise = io.add & ~add_q;
  assign sub_rise = io.sub & ~sub_q;

  // simultaneous add/sub edges cancel and fall through to timekeeping
  assign adj = !io.hold && (add_rise ^ sub_rise);
  assign adv = !io.hold && !adj && io.run && (pre == CNT_W'(DIV - 1));

  assign sec_inc = adv || (adj && add_rise && !io.sel);
  assign sec_dec = adj && sub_rise && !io.sel;
  assign min_inc = (adv && sec_wrap) || (adj && add_rise && io.sel);
  assign min_dec = adj && sub_rise && io.sel;

  // edge registers track the buttons even during hold, so held edges are consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_q <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      add_q <= io.add;
      sub_q <= io.sub;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (io.hold) begin
      pre <= pre;
    end else if (adj) begin
      pre <= '0;
    end else if (io.run) begin
      pre <= adv ? '0 : pre + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.tick     <= 1'b0;
      io.hour_add <= 1'b0;
    end else begin
      io.tick     <= adv;
      io.hour_add <= adv && sec_wrap && min_wrap;
    end
  end

  bcd60_counter u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .dec   (sec_dec),
    .en    (!io.hold),
    .low   (io.sec_low),
    .high  (io.sec_high),
    .wrap  (sec_wrap)
  );

  bcd60_counter u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .dec   (min_dec),
    .en    (!io.hold),
    .low   (io.min_low),
    .high  (io.min_high),
    .wrap  (min_wrap)
  );

endmodule

// File: tb/tb_clock_mmss_counter.sv
// Directed bench for clock_mmss_counter with DIV=4: vector table plus corner sequences.
module tb_clock_mmss_counter;

  localparam int DIV = 4;

  typedef struct {
    logic       rst_n;
    logic       run;
    logic       hold;
    logic       sel;
    logic       add;
    logic       sub;
    logic [7:0] sec;
    logic [7:0] mn;
    logic       tick;
    logic       ha;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  clock_mmss_counter_if io ();

  clock_mmss_counter #(.DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  function automatic vec_t mk(input logic r, ru, h, s, a, b,
                              input logic [7:0] es, em, input logic et, eh);
    vec_t v;
    v.rst_n = r; v.run = ru; v.hold = h; v.sel = s; v.add = a; v.sub = b;
    v.sec = es; v.mn = em; v.tick = et; v.ha = eh;
    return v;
  endfunction

  task automatic step(input logic r, ru, h, s, a, b);
    @(negedge clk);
    rst_n = r; io.run = ru; io.hold = h; io.sel = s; io.add = a; io.sub = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] es, em, input logic et, eh);
    logic [7:0] gs, gm;
    gs = {io.sec_high, io.sec_low};
    gm = {io.min_high, io.min_low};
    n_cmp++;
    if ({gs, gm, io.tick, io.hour_add} !== {es, em, et, eh}) begin
      n_bad++;
      $display("FAIL %s: got %02h:%02h tick=%0b hour_add=%0b, want %02h:%02h tick=%0b hour_add=%0b",
               nm, gm, gs, io.tick, io.hour_add, em, es, et, eh);
    end
  endtask

  task automatic pulse(input logic s, input logic up);
    step(1, 0, 0, s, up, !up);
    step(1, 0, 0, s, 0, 0);
  endtask

  initial begin
    io.run = 0; io.hold = 0; io.sel = 0; io.add = 0; io.sub = 0;

    // reset, then first ticks every DIV cycles
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00,8'h00,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h00,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h00,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h00,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h01,8'h00,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h01,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h01,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h01,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h02,8'h00,1,0));
    // preset 59:59 by borrows, then roll over to 00:00 with hour_add
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,1, 8'h59,8'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 8'h59,8'h00,0,0));
    vecs.push_back(mk(1,0,0,1,0,1, 8'h59,8'h59,0,0));
    vecs.push_back(mk(1,0,0,1,0,0, 8'h59,8'h59,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h59,8'h59,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h59,8'h59,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h59,8'h59,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h00,8'h00,1,1));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h00,8'h00,0,0));
    // add and sub rising together: no adjust, prescaler keeps counting
    vecs.push_back(mk(1,1,0,0,1,1, 8'h00,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 8'h00,8'h00,0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 8'h01,8'h00,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h01,8'h00,0,0));
    // held add on minutes counts once
    vecs.push_back(mk(1,0,0,1,1,0, 8'h01,8'h01,0,0));
    vecs.push_back(mk(1,0,0,1,1,0, 8'h01,8'h01,0,0));
    vecs.push_back(mk(1,0,0,1,1,0, 8'h01,8'h01,0,0));
    vecs.push_back(mk(1,0,0,1,0,0, 8'h01,8'h01,0,0));

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].run, vecs[i].hold, vecs[i].sel, vecs[i].add, vecs[i].sub);
      chk($sformatf("vec%0d", i), vecs[i].sec, vecs[i].mn, vecs[i].tick, vecs[i].ha);
    end

    // seconds 09 -> 10
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) pulse(0, 1);
    chk("preset_09", 8'h09, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("carry_09_10", 8'h10, 8'h00, 1, 0);

    // 00:59 -> 01:00 without hour_add
    step(0, 0, 0, 0, 0, 0);
    pulse(0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    chk("carry_0059", 8'h00, 8'h01, 1, 0);

    // hold mid-prescaler with an add edge inside
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, 0, (i == 4 || i == 5), 0);
      chk($sformatf("hold%0d", i), 8'h00, 8'h00, 0, 0);
    end
    step(1, 1, 0, 0, 0, 0);
    chk("hold_rel1", 8'h00, 8'h00, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("hold_rel2", 8'h01, 8'h00, 1, 0);

    // add held 20 cycles on minutes
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 1, 0);
    chk("add_held20", 8'h01, 8'h01, 0, 0);
    step(1, 0, 0, 1, 0, 0);

    // adjust on the tick cycle drops the tick and restarts the prescaler
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    chk("adj_on_tick", 8'h02, 8'h01, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    chk("adj_restart3", 8'h02, 8'h01, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("adj_restart4", 8'h03, 8'h01, 1, 0);

    // mid-run reset at 12:34 with prescaler 3
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) pulse(1, 1);
    for (int i = 0; i < 34; i++) pulse(0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    chk("preset_1234", 8'h34, 8'h12, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("midrun_reset", 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    chk("post_reset3", 8'h00, 8'h00, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("post_reset4", 8'h01, 8'h00, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
